pcpi_initiator: RTL and testbench

- CPU-side master of the PCPI coprocessor interface; the counterpart of PCPI responders such as the multiplier.
- Accepts one custom/M-extension instruction with its operands from the core over a valid/ready request channel.
- Drives the PCPI request and waits for a responder's pcpi_ready, or traps on timeout when no responder claims the instruction.
- Returns result, write-enable and trap status to the core over a valid/ready response channel.

---
 rtl/pcpi_pkg.sv | 24 ++
 rtl/pcpi_timeout_counter.sv | 32 +++
 rtl/pcpi_initiator.sv | 140 ++++++++++++++
 tb/tb_pcpi_initiator.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcpi_pkg.sv
// Shared types and constants for the PCPI initiator and its bench.
package pcpi_pkg;

  // Initiator transaction phases.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } pcpi_state_e;

  // RV32 M-extension encoding fields (R-type OP with funct7 = 1).
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;

  // Cycles a request may sit unclaimed (no wait, no ready) before trapping.
  localparam int TIMEOUT_DEFAULT = 16;
  localparam int CNT_W_DEFAULT   = 8;

endpackage

// File: rtl/pcpi_timeout_counter.sv
// Down-counter watching for an unclaimed PCPI request.
// load reloads to TIMEOUT (priority over dec); dec counts down and sticks at 0.
// zero flags that the unclaimed budget is used up.
module pcpi_timeout_counter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q;

  // Counter register: reload on request start or responder wait, else count down.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= RELOAD;
    end else if (load) begin
      cnt_q <= RELOAD;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pcpi_initiator.sv
// CPU-side PCPI master: takes one instruction from the core, offers it on
// PCPI, waits for a responder (or traps when nobody claims it) and hands the
// result back to the core.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// req_ready is high only in IDLE; rsp_valid is high only in RESP, and the
// response fields stay stable while rsp_valid is high until rsp_ready.
// pcpi_ready/pcpi_wait are only looked at while pcpi_valid is high.
module pcpi_initiator
  import pcpi_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  // core request channel
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_insn,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  // core response channel
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_wr,
  output logic [31:0] rsp_rd,
  output logic        rsp_trap,
  // PCPI bus
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  input  logic        pcpi_wait,
  input  logic        pcpi_ready,
  // debug view of the phase
  output logic [1:0]  dbg_state
);

  pcpi_state_e state_q, state_d;

  logic accept;     // request handshake this cycle
  logic take_rsp;   // responder delivers a result this cycle
  logic take_trap;  // unclaimed budget exhausted this cycle
  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;

  pcpi_timeout_counter #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout (
    .clk    (clk),
    .resetn (resetn),
    .load   (cnt_load),
    .dec    (cnt_dec),
    .zero   (cnt_zero)
  );

  // Event decode and counter control; pcpi_ready outranks pcpi_wait.
  always_comb begin
    accept    = 1'b0;
    take_rsp  = 1'b0;
    take_trap = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    if (state_q == IDLE) begin
      accept   = req_valid;
      cnt_load = req_valid;
    end else if (state_q == ISSUE) begin
      if (pcpi_ready) begin
        take_rsp = 1'b1;
      end else if (pcpi_wait) begin
        cnt_load = 1'b1;
      end else if (cnt_zero) begin
        take_trap = 1'b1;
      end else begin
        cnt_dec = 1'b1;
      end
    end
  end

  // Next-phase selection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   if (take_rsp || take_trap) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Phase register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request capture: operands are frozen for the whole ISSUE phase.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pcpi_insn <= '0;
      pcpi_rs1  <= '0;
      pcpi_rs2  <= '0;
    end else if (accept) begin
      pcpi_insn <= req_insn;
      pcpi_rs1  <= req_rs1;
      pcpi_rs2  <= req_rs2;
    end
  end

  // Response capture: responder result or an illegal-instruction trap.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_rd   <= '0;
      rsp_wr   <= 1'b0;
      rsp_trap <= 1'b0;
    end else if (take_rsp) begin
      rsp_rd   <= pcpi_rd;
      rsp_wr   <= pcpi_wr;
      rsp_trap <= 1'b0;
    end else if (take_trap) begin
      rsp_rd   <= '0;
      rsp_wr   <= 1'b0;
      rsp_trap <= 1'b1;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign pcpi_valid = (state_q == ISSUE);
  assign rsp_valid  = (state_q == RESP);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_pcpi_initiator.sv
// Bench for pcpi_initiator. Each transaction is expanded up front into a
// per-cycle timeline of inputs and the outputs the core/PCPI rules demand;
// one process replays the inputs and checks the outputs every cycle.
module tb_pcpi_initiator;
  import pcpi_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 8;
  localparam int EW      = 135;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid, req_ready;
  logic [31:0] req_insn, req_rs1, req_rs2;
  logic        rsp_valid, rsp_ready, rsp_wr, rsp_trap;
  logic [31:0] rsp_rd;
  logic        pcpi_valid, pcpi_wr, pcpi_wait, pcpi_ready;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2, pcpi_rd;
  logic [1:0]  dbg_state;

  pcpi_initiator #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_insn(req_insn),
    .req_rs1(req_rs1), .req_rs2(req_rs2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
    .rsp_rd(rsp_rd), .rsp_trap(rsp_trap),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1),
    .pcpi_rs2(pcpi_rs2), .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
    .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
    .dbg_state(dbg_state)
  );

  // ---------------- timelines ----------------
  typedef struct {
    logic        req_valid;
    logic [31:0] insn, rs1, rs2;
    logic        rsp_ready;
    logic        pw, pr, pwr;
    logic [31:0] prd;
  } stim_t;

  stim_t            stim_q[$];
  logic [EW-1:0]    exp_q[$];
  logic [1:0]       scr_q[$];   // responder script per ISSUE cycle: {wait, ready}

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at time %0t", name, act, expv, $time);
    end
  endtask

  // Expected outputs: {req_ready, pcpi_valid, rsp_valid, chk_pcpi, chk_rsp,
  //                    insn, rs1, rs2, rd, wr, trap}
  function automatic logic [EW-1:0] pack_exp(logic rr, logic pv, logic rv, logic cp, logic cr,
                                             logic [31:0] insn, logic [31:0] rs1, logic [31:0] rs2,
                                             logic [31:0] rd, logic wr, logic trap);
    return {rr, pv, rv, cp, cr, insn, rs1, rs2, rd, wr, trap};
  endfunction

  // Reference multiply: 64-bit product of sign- or zero-extended operands.
  function automatic logic [31:0] mul_ref(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (f3 == F3_MULH || f3 == F3_MULHSU) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (f3 == F3_MULH) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (f3 == F3_MUL) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] mk_insn(logic [2:0] f3);
    return {FUNCT7_MULDIV, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), f3,
            5'($urandom_range(0, 31)), OPCODE_OP};
  endfunction

  function automatic stim_t noise();
    stim_t s;
    s.req_valid = 1'($urandom_range(0, 1));
    s.insn      = $urandom;
    s.rs1       = $urandom;
    s.rs2       = $urandom;
    s.rsp_ready = 1'($urandom_range(0, 1));
    s.pw        = ($urandom_range(0, 3) == 0);
    s.pr        = ($urandom_range(0, 3) == 0);
    s.pwr       = 1'($urandom_range(0, 1));
    s.prd       = $urandom;
    return s;
  endfunction

  task automatic build_idle(input int n);
    stim_t s;
    for (int i = 0; i < n; i++) begin
      s = noise();
      s.req_valid = 1'b0;
      stim_q.push_back(s);
      exp_q.push_back(pack_exp(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  // One transaction: idle gap, accept, ISSUE driven by scr_q, RESP held hold_k cycles.
  // The ISSUE phase ends on ready, or once TIMEOUT+1 consecutive cycles pass
  // with neither wait nor ready.
  task automatic build_txn(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [31:0] rd_val, input logic wr_val,
                           input int idle_gap, input int hold_k, input bit spur,
                           output int issue_len, output logic trap);
    stim_t s;
    int run;
    bit done;
    logic [1:0] sc;
    logic [31:0] e_rd;
    logic e_wr;
    build_idle(idle_gap);
    s = noise();
    s.req_valid = 1'b1; s.insn = insn; s.rs1 = rs1; s.rs2 = rs2;
    stim_q.push_back(s);
    exp_q.push_back(pack_exp(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run = 0; done = 0; issue_len = 0; trap = 0; e_rd = 0; e_wr = 0;
    while (!done) begin
      s = noise();
      sc = (scr_q.size() > 0) ? scr_q.pop_front() : 2'b00;
      s.pw = sc[1];
      s.pr = sc[0];
      if (sc[0]) begin
        s.prd = rd_val;
        s.pwr = wr_val;
      end
      stim_q.push_back(s);
      exp_q.push_back(pack_exp(0, 1, 0, 1, 0, insn, rs1, rs2, 0, 0, 0));
      issue_len++;
      if (sc[0]) begin
        e_rd = rd_val; e_wr = wr_val; trap = 0; done = 1;
      end else if (sc[1]) begin
        run = 0;
      end else begin
        run++;
        if (run == TIMEOUT + 1) begin
          e_rd = 0; e_wr = 0; trap = 1; done = 1;
        end
      end
    end
    scr_q.delete();
    for (int j = 0; j <= hold_k; j++) begin
      s = noise();
      s.rsp_ready = (j == hold_k);
      if (spur) s.pr = 1'b1;
      stim_q.push_back(s);
      exp_q.push_back(pack_exp(0, 0, 1, 0, 1, 0, 0, 0, e_rd, e_wr, trap));
    end
  endtask

  // ---------------- compare / drive ----------------
  task automatic run_q();
    stim_t s;
    logic [EW-1:0] e;
    while (stim_q.size() > 0) begin
      @(negedge clk);
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      check("req_ready",  req_ready,  e[134]);
      check("pcpi_valid", pcpi_valid, e[133]);
      check("rsp_valid",  rsp_valid,  e[132]);
      if (e[131]) begin
        check("pcpi_insn", pcpi_insn, e[129:98]);
        check("pcpi_rs1",  pcpi_rs1,  e[97:66]);
        check("pcpi_rs2",  pcpi_rs2,  e[65:34]);
      end
      if (e[130]) begin
        check("rsp_rd",   rsp_rd,   e[33:2]);
        check("rsp_wr",   rsp_wr,   e[1]);
        check("rsp_trap", rsp_trap, e[0]);
      end
      req_valid  = s.req_valid;
      req_insn   = s.insn;
      req_rs1    = s.rs1;
      req_rs2    = s.rs2;
      rsp_ready  = s.rsp_ready;
      pcpi_wait  = s.pw;
      pcpi_ready = s.pr;
      pcpi_wr    = s.pwr;
      pcpi_rd    = s.prd;
    end
  endtask

  task automatic rst_checks(input string tag);
    check({tag, "_req_ready"},  req_ready,  1);
    check({tag, "_pcpi_valid"}, pcpi_valid, 0);
    check({tag, "_rsp_valid"},  rsp_valid,  0);
    check({tag, "_rsp_rd"},     rsp_rd,     0);
    check({tag, "_rsp_wr"},     rsp_wr,     0);
    check({tag, "_rsp_trap"},   rsp_trap,   0);
    check({tag, "_pcpi_insn"},  pcpi_insn,  0);
    check({tag, "_pcpi_rs1"},   pcpi_rs1,   0);
    check({tag, "_pcpi_rs2"},   pcpi_rs2,   0);
    check({tag, "_dbg_state"},  32'(dbg_state), 32'(IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int len;
    logic trap;
    logic [31:0] a, b, ins;
    logic [2:0] f3;
    int kind;

    req_valid = 0; req_insn = 0; req_rs1 = 0; req_rs2 = 0; rsp_ready = 0;
    pcpi_wr = 0; pcpi_rd = 0; pcpi_wait = 0; pcpi_ready = 0;
    repeat (3) @(negedge clk);
    rst_checks("reset");
    resetn = 1'b1;

    // model pins
    check("model_mul",   mul_ref(F3_MUL, 32'd7, 32'd6), 32'd42);
    check("model_mulh",  mul_ref(F3_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'h0000_0000);
    check("model_mulhu", mul_ref(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);

    // MUL 7*6 with two busy cycles
    scr_q = '{2'b10, 2'b10, 2'b01};
    build_txn(mk_insn(F3_MUL), 32'd7, 32'd6, mul_ref(F3_MUL, 32'd7, 32'd6), 1'b1, 1, 0, 0, len, trap);
    check("len_mul", len, 3);
    // MULH and MULHU of -1,-1 (MULHU answers with wait and ready together)
    scr_q = '{2'b01};
    build_txn(mk_insn(F3_MULH), 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              mul_ref(F3_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 1'b1, 0, 1, 0, len, trap);
    scr_q = '{2'b11};
    build_txn(mk_insn(F3_MULHU), 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              mul_ref(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 1'b1, 0, 0, 0, len, trap);
    // nobody claims a custom-0 instruction
    build_txn(32'h0000_000B, 32'd1, 32'd2, 32'd0, 1'b0, 2, 0, 0, len, trap);
    check("len_noresp", len, TIMEOUT + 1);
    check("trap_noresp", trap, 1);
    // long wait then ready
    for (int i = 0; i < 40; i++) scr_q.push_back(2'b10);
    scr_q.push_back(2'b01);
    build_txn(32'h0000_002B, 32'd3, 32'd4, 32'h1234, 1'b1, 0, 0, 0, len, trap);
    check("len_wait40", len, 41);
    check("trap_wait40", trap, 0);
    // long wait, then wait dropped for TIMEOUT+1 cycles: trap before ready
    for (int i = 0; i < 40; i++) scr_q.push_back(2'b10);
    for (int i = 0; i < 17; i++) scr_q.push_back(2'b00);
    scr_q.push_back(2'b01);
    build_txn(32'h0000_002B, 32'd3, 32'd4, 32'h1234, 1'b1, 0, 0, 0, len, trap);
    check("len_gap17", len, 57);
    check("trap_gap17", trap, 1);
    // core stalls the response for 5 cycles while a stray pcpi_ready is asserted
    scr_q = '{2'b01};
    build_txn(mk_insn(F3_MUL), 32'd100, 32'd3, 32'd300, 1'b1, 0, 5, 1, len, trap);
    build_idle(2);
    run_q();

    // reset during the third ISSUE cycle
    @(negedge clk);
    req_valid = 1; req_insn = mk_insn(F3_MUL); req_rs1 = 32'd5; req_rs2 = 32'd9;
    pcpi_wait = 0; pcpi_ready = 0; rsp_ready = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      req_valid = 0;
      check("rst_issue_pv", pcpi_valid, 1);
    end
    #2;
    pcpi_ready = 1; pcpi_wr = 1; pcpi_rd = 32'hDEAD_BEEF;
    resetn = 1'b0;
    #1;
    rst_checks("midreset");
    @(negedge clk);
    rst_checks("midreset_hold");
    pcpi_ready = 0; pcpi_wr = 0;
    resetn = 1'b1;
    scr_q = '{2'b10, 2'b01};
    build_txn(mk_insn(F3_MUL), 32'd11, 32'd13, 32'd143, 1'b1, 0, 0, 0, len, trap);
    build_idle(1);
    run_q();

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 4);
      a = $urandom;
      b = $urandom;
      if (kind <= 2) begin
        f3 = 3'($urandom_range(0, 3));
        ins = mk_insn(f3);
        for (int i = 0; i < int'($urandom_range(0, 6)); i++) scr_q.push_back(2'b10);
        scr_q.push_back({1'($urandom_range(0, 1)), 1'b1});
        build_txn(ins, a, b, mul_ref(f3, a, b), 1'b1, $urandom_range(0, 3),
                  $urandom_range(0, 3), 1'($urandom_range(0, 1)), len, trap);
      end else if (kind == 3) begin
        build_txn($urandom, a, b, 32'd0, 1'b0, $urandom_range(0, 3),
                  $urandom_range(0, 3), 1'($urandom_range(0, 1)), len, trap);
      end else begin
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
          for (int i = 0; i < int'($urandom_range(0, 10)); i++) scr_q.push_back(2'b10);
          for (int i = 0; i < int'($urandom_range(0, 18)); i++) scr_q.push_back(2'b00);
        end
        if ($urandom_range(0, 1) == 1) scr_q.push_back(2'b01);
        build_txn($urandom, a, b, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                  $urandom_range(0, 3), 1'($urandom_range(0, 1)), len, trap);
      end
    end
    build_idle(2);
    run_q();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
